// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared cause codes, exception bit indexes and FSM states for the trap controller
package trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COMMIT   = 2'd1,
    ST_REDIRECT = 2'd2
  } trap_state_e;

  localparam int EXC_INST_MIS = 0;
  localparam int EXC_ILLEGAL  = 1;
  localparam int EXC_EBREAK   = 2;
  localparam int EXC_ECALL    = 3;
  localparam int EXC_LD_MIS   = 4;
  localparam int EXC_ST_MIS   = 5;

  localparam logic [4:0] CAUSE_INST_MIS = 5'd0;
  localparam logic [4:0] CAUSE_ILLEGAL  = 5'd2;
  localparam logic [4:0] CAUSE_EBREAK   = 5'd3;
  localparam logic [4:0] CAUSE_LD_MIS   = 5'd4;
  localparam logic [4:0] CAUSE_ST_MIS   = 5'd6;
  localparam logic [4:0] CAUSE_ECALL    = 5'd11;

  localparam logic [4:0] IRQ_MSI       = 5'd3;
  localparam logic [4:0] IRQ_MTI       = 5'd7;
  localparam logic [4:0] IRQ_MEI       = 5'd11;
  localparam logic [4:0] IRQ_PLAT_BASE = 5'd16;

  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

endpackage

// File: rtl/trap_irq_arbiter.sv
// rtl/trap_irq_arbiter.sv - interrupt pending latches, enable masking and fixed-priority pick
module trap_irq_arbiter
  import trap_pkg::*;
#(
  parameter int                      XLEN         = 32,
  parameter int                      NUM_PLAT_IRQ = 4,
  parameter logic [NUM_PLAT_IRQ-1:0] IRQ_EDGE     = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    meip_i,
  input  logic                    mtip_i,
  input  logic                    msip_i,
  input  logic [NUM_PLAT_IRQ-1:0] plat_irq_i,
  input  logic                    mstatus_mie_i,
  input  logic [XLEN-1:0]         mie_i,
  input  logic                    clear_i,
  output logic                    take_o,
  output logic [4:0]              code_o
);

  logic [NUM_PLAT_IRQ-1:0] r_plat_prev;
  logic [NUM_PLAT_IRQ-1:0] r_edge_pend;
  logic [NUM_PLAT_IRQ-1:0] w_plat_pend;
  logic [NUM_PLAT_IRQ-1:0] w_plat_clr;
  logic [XLEN-1:0]         w_pend_vec;
  logic [XLEN-1:0]         w_act;

  always_comb begin
    w_plat_pend = '0;
    for (int i = 0; i < NUM_PLAT_IRQ; i++) begin
      w_plat_pend[i] = IRQ_EDGE[i] ? r_edge_pend[i] : plat_irq_i[i];
    end
  end

  // Pending lines are placed at their cause-code bit so mie_i masks them directly.
  always_comb begin
    w_pend_vec          = '0;
    w_pend_vec[IRQ_MEI] = meip_i;
    w_pend_vec[IRQ_MSI] = msip_i;
    w_pend_vec[IRQ_MTI] = mtip_i;
    for (int i = 0; i < NUM_PLAT_IRQ; i++) begin
      w_pend_vec[int'(IRQ_PLAT_BASE) + i] = w_plat_pend[i];
    end
  end

  assign w_act  = w_pend_vec & mie_i & {XLEN{mstatus_mie_i}};
  assign take_o = |w_act;

  always_comb begin
    code_o = '0;
    if (w_act[IRQ_MEI]) begin
      code_o = IRQ_MEI;
    end else if (w_act[IRQ_MSI]) begin
      code_o = IRQ_MSI;
    end else if (w_act[IRQ_MTI]) begin
      code_o = IRQ_MTI;
    end else begin
      for (int i = NUM_PLAT_IRQ - 1; i >= 0; i--) begin
        if (w_act[int'(IRQ_PLAT_BASE) + i]) code_o = IRQ_PLAT_BASE + 5'(i);
      end
    end
  end

  always_comb begin
    w_plat_clr = '0;
    for (int i = 0; i < NUM_PLAT_IRQ; i++) begin
      w_plat_clr[i] = clear_i && (code_o == IRQ_PLAT_BASE + 5'(i));
    end
  end

  // A fresh rising edge in the same cycle as the clear keeps the line pending.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_plat_prev <= '0;
      r_edge_pend <= '0;
    end else begin
      r_plat_prev <= plat_irq_i;
      r_edge_pend <= ((r_edge_pend & ~w_plat_clr) | (plat_irq_i & ~r_plat_prev)) & IRQ_EDGE;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap controller: arbitration, CSR commit sequencing and fetch redirect
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int                      XLEN         = 32,
  parameter int                      NUM_PLAT_IRQ = 4,
  parameter logic [NUM_PLAT_IRQ-1:0] IRQ_EDGE     = '0,
  parameter int                      VECTORED     = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wb_valid_i,
  input  logic [XLEN-1:0]         pc_i,
  input  logic [31:0]             instruction_i,
  input  logic [XLEN-1:0]         mem_addr_i,
  input  logic [5:0]              exc_i,
  input  logic                    mret_i,
  input  logic                    xint_meip_i,
  input  logic                    xint_mtip_i,
  input  logic                    xint_msip_i,
  input  logic [NUM_PLAT_IRQ-1:0] plat_irq_i,
  input  logic                    mstatus_mie_i,
  input  logic [XLEN-1:0]         mie_i,
  input  logic [XLEN-1:0]         mtvec_i,
  input  logic [XLEN-1:0]         mepc_i,
  output logic                    kill_wb_o,
  output logic                    busy_o,
  output logic                    flush_o,
  output logic                    csr_we_o,
  output logic [XLEN-1:0]         mcause_o,
  output logic [XLEN-1:0]         mepc_o,
  output logic [XLEN-1:0]         mtval_o,
  output logic                    trap_enter_o,
  output logic                    trap_ret_o,
  output logic                    redirect_valid_o,
  output logic [XLEN-1:0]         redirect_pc_o,
  input  logic                    redirect_ready_i
);

  trap_state_e     r_state, w_state_nxt;
  logic [XLEN-1:0] r_cause, r_mtval, r_mepc, r_target;
  logic            r_ret_first;

  logic            w_irq_take;
  logic [4:0]      w_irq_code;
  logic            w_idle_evt, w_take_irq, w_take_exc, w_take_mret;
  logic [XLEN-1:0] w_base, w_cause, w_mtval, w_target;

  trap_irq_arbiter #(
    .XLEN         (XLEN),
    .NUM_PLAT_IRQ (NUM_PLAT_IRQ),
    .IRQ_EDGE     (IRQ_EDGE)
  ) u_arb (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .meip_i        (xint_meip_i),
    .mtip_i        (xint_mtip_i),
    .msip_i        (xint_msip_i),
    .plat_irq_i    (plat_irq_i),
    .mstatus_mie_i (mstatus_mie_i),
    .mie_i         (mie_i),
    .clear_i       (w_take_irq),
    .take_o        (w_irq_take),
    .code_o        (w_irq_code)
  );

  assign w_idle_evt  = rst_i && (r_state == ST_IDLE) && wb_valid_i;
  assign w_take_irq  = w_idle_evt && w_irq_take;
  assign w_take_exc  = w_idle_evt && !w_irq_take && (|exc_i);
  assign w_take_mret = w_idle_evt && !w_irq_take && !(|exc_i) && mret_i;
  assign w_base      = {mtvec_i[XLEN-1:2], 2'b00};

  always_comb begin
    w_cause = '0;
    w_mtval = '0;
    if (w_irq_take) begin
      w_cause[XLEN-1] = 1'b1;
      w_cause[4:0]    = w_irq_code;
    end else if (exc_i[EXC_INST_MIS]) begin
      w_cause[4:0] = CAUSE_INST_MIS;
      w_mtval      = pc_i;
    end else if (exc_i[EXC_ILLEGAL]) begin
      w_cause[4:0] = CAUSE_ILLEGAL;
      w_mtval      = XLEN'(instruction_i);
    end else if (exc_i[EXC_EBREAK]) begin
      w_cause[4:0] = CAUSE_EBREAK;
      w_mtval      = pc_i;
    end else if (exc_i[EXC_ECALL]) begin
      w_cause[4:0] = CAUSE_ECALL;
    end else if (exc_i[EXC_LD_MIS]) begin
      w_cause[4:0] = CAUSE_LD_MIS;
      w_mtval      = mem_addr_i;
    end else if (exc_i[EXC_ST_MIS]) begin
      w_cause[4:0] = CAUSE_ST_MIS;
      w_mtval      = mem_addr_i;
    end
  end

  // Only interrupts are vectored; exceptions always land on the masked base.
  always_comb begin
    w_target = w_base;
    if (w_irq_take && (VECTORED != 0) && (mtvec_i[1:0] == MTVEC_VECTORED)) begin
      w_target = w_base + (XLEN'(w_irq_code) << 2);
    end else if (!w_irq_take && !(|exc_i) && mret_i) begin
      w_target = mepc_i;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    kill_wb_o        = 1'b0;
    busy_o           = 1'b0;
    flush_o          = 1'b0;
    csr_we_o         = 1'b0;
    trap_enter_o     = 1'b0;
    trap_ret_o       = 1'b0;
    redirect_valid_o = 1'b0;
    if (rst_i) begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_take_irq || w_take_exc || w_take_mret) begin
            kill_wb_o   = 1'b1;
            flush_o     = 1'b1;
            w_state_nxt = w_take_mret ? ST_REDIRECT : ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          busy_o       = 1'b1;
          flush_o      = 1'b1;
          csr_we_o     = 1'b1;
          trap_enter_o = 1'b1;
          w_state_nxt  = ST_REDIRECT;
        end
        ST_REDIRECT: begin
          busy_o           = 1'b1;
          flush_o          = 1'b1;
          redirect_valid_o = 1'b1;
          trap_ret_o       = r_ret_first;
          if (redirect_ready_i) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state     <= ST_IDLE;
      r_cause     <= '0;
      r_mtval     <= '0;
      r_mepc      <= '0;
      r_target    <= '0;
      r_ret_first <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ret_first <= w_take_mret;
      if (w_take_irq || w_take_exc || w_take_mret) begin
        r_cause  <= w_cause;
        r_mtval  <= w_mtval;
        r_mepc   <= pc_i;
        r_target <= w_target;
      end
    end
  end

  assign mcause_o      = r_cause;
  assign mepc_o        = r_mepc;
  assign mtval_o       = r_mtval;
  assign redirect_pc_o = r_target;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - table-driven and randomized checks of trap_ctrl against a behavioural model
module tb_trap_ctrl;

  localparam int K_NONE = 0;
  localparam int K_TRAP = 1;
  localparam int K_MRET = 2;

  typedef struct {
    logic        wb;
    logic [5:0]  exc;
    logic        mret, meip, mtip, msip;
    logic [3:0]  plat;
    logic        mie_g;
    logic [31:0] mie, mtvec, pc, instr, addr, mepc;
    int          kind;
    logic [31:0] cause, mtval, target;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_i, wb_valid_i, mret_i, xint_meip_i, xint_mtip_i, xint_msip_i;
  logic        mstatus_mie_i, redirect_ready_i;
  logic [31:0] pc_i, instruction_i, mem_addr_i, mie_i, mtvec_i, mepc_i;
  logic [5:0]  exc_i;
  logic [3:0]  plat_irq_i;
  logic        kill_wb_o, busy_o, flush_o, csr_we_o, trap_enter_o, trap_ret_o, redirect_valid_o;
  logic [31:0] mcause_o, mepc_o, mtval_o, redirect_pc_o;

  int n_pass  = 0;
  int n_total = 0;
  bit m_edge  = 1'b0;

  always #5 clk = ~clk;

  trap_ctrl #(.XLEN(32), .NUM_PLAT_IRQ(4), .IRQ_EDGE(4'b0001), .VECTORED(1)) dut (
    .clk_i(clk), .rst_i(rst_i), .wb_valid_i(wb_valid_i), .pc_i(pc_i),
    .instruction_i(instruction_i), .mem_addr_i(mem_addr_i), .exc_i(exc_i), .mret_i(mret_i),
    .xint_meip_i(xint_meip_i), .xint_mtip_i(xint_mtip_i), .xint_msip_i(xint_msip_i),
    .plat_irq_i(plat_irq_i), .mstatus_mie_i(mstatus_mie_i), .mie_i(mie_i), .mtvec_i(mtvec_i),
    .mepc_i(mepc_i), .kill_wb_o(kill_wb_o), .busy_o(busy_o), .flush_o(flush_o),
    .csr_we_o(csr_we_o), .mcause_o(mcause_o), .mepc_o(mepc_o), .mtval_o(mtval_o),
    .trap_enter_o(trap_enter_o), .trap_ret_o(trap_ret_o), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o), .redirect_ready_i(redirect_ready_i)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic wb, input logic [5:0] exc, input logic mret,
                              input logic meip, input logic mtip, input logic msip,
                              input logic [3:0] plat, input logic mie_g, input logic [31:0] mie,
                              input logic [31:0] mtvec, input logic [31:0] pc,
                              input logic [31:0] instr, input logic [31:0] addr,
                              input logic [31:0] mepc, input int kind, input logic [31:0] cause,
                              input logic [31:0] mtval, input logic [31:0] target);
    vec_t v;
    v.wb = wb; v.exc = exc; v.mret = mret; v.meip = meip; v.mtip = mtip; v.msip = msip;
    v.plat = plat; v.mie_g = mie_g; v.mie = mie; v.mtvec = mtvec; v.pc = pc;
    v.instr = instr; v.addr = addr; v.mepc = mepc; v.kind = kind; v.cause = cause;
    v.mtval = mtval; v.target = target;
    return v;
  endfunction

  // Reference: walk the documented priority lists; plat[0] pending comes from the bench's own edge record.
  function automatic vec_t model(input vec_t v, input bit edge_pend);
    vec_t        r = v;
    int          prio[7] = '{11, 3, 7, 16, 17, 18, 19};
    int          exc_cause[6] = '{0, 2, 3, 11, 4, 6};
    logic [31:0] pend = '0;
    pend[11] = v.meip; pend[3] = v.msip; pend[7] = v.mtip; pend[16] = edge_pend;
    for (int i = 1; i < 4; i++) pend[16 + i] = v.plat[i];
    r.kind = K_NONE; r.cause = '0; r.mtval = '0; r.target = {v.mtvec[31:2], 2'b00};
    if (!v.wb) return r;
    for (int i = 0; i < 7; i++) begin
      if (v.mie_g && v.mie[prio[i]] && pend[prio[i]]) begin
        r.kind  = K_TRAP;
        r.cause = 32'h8000_0000 | 32'(prio[i]);
        if (v.mtvec[1:0] == 2'b01) r.target = r.target + 32'(4 * prio[i]);
        return r;
      end
    end
    for (int i = 0; i < 6; i++) begin
      if (v.exc[i]) begin
        r.kind  = K_TRAP;
        r.cause = 32'(exc_cause[i]);
        case (i)
          0, 2:    r.mtval = v.pc;
          1:       r.mtval = v.instr;
          3:       r.mtval = '0;
          default: r.mtval = v.addr;
        endcase
        return r;
      end
    end
    if (v.mret) begin
      r.kind   = K_MRET;
      r.target = v.mepc;
    end
    return r;
  endfunction

  task automatic drive(input vec_t v);
    wb_valid_i = v.wb; exc_i = v.exc; mret_i = v.mret; xint_meip_i = v.meip;
    xint_mtip_i = v.mtip; xint_msip_i = v.msip; plat_irq_i = v.plat; mstatus_mie_i = v.mie_g;
    mie_i = v.mie; mtvec_i = v.mtvec; pc_i = v.pc; instruction_i = v.instr;
    mem_addr_i = v.addr; mepc_i = v.mepc;
  endtask

  task automatic idle_inputs();
    wb_valid_i = 1'b0; exc_i = '0; mret_i = 1'b0; xint_meip_i = 1'b0; xint_mtip_i = 1'b0;
    xint_msip_i = 1'b0; plat_irq_i = '0; redirect_ready_i = 1'b0;
  endtask

  // Entered and left at posedge+1; plat[0] optionally pulsed during the COMMIT cycle.
  task automatic do_event(input vec_t v, input int rdy_dly, input bit pulse);
    drive(v);
    @(negedge clk);
    chk1("kill_wb_N", kill_wb_o, v.kind != K_NONE);
    chk1("flush_N", flush_o, v.kind != K_NONE);
    chk1("busy_N", busy_o, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    if (v.kind == K_NONE) begin
      @(negedge clk);
      chk1("busy_no_event", busy_o, 1'b0);
      chk1("csr_we_no_event", csr_we_o, 1'b0);
      @(posedge clk); #1;
      return;
    end
    if (v.kind == K_TRAP) begin
      if (pulse) plat_irq_i[0] = 1'b1;
      @(negedge clk);
      chk1("csr_we_commit", csr_we_o, 1'b1);
      chk1("trap_enter_commit", trap_enter_o, 1'b1);
      chk1("busy_commit", busy_o, 1'b1);
      chk1("kill_wb_commit", kill_wb_o, 1'b0);
      chk1("redirect_valid_commit", redirect_valid_o, 1'b0);
      chk("mcause", mcause_o, v.cause);
      chk("mepc", mepc_o, v.pc);
      chk("mtval", mtval_o, v.mtval);
      @(posedge clk); #1;
      plat_irq_i[0] = 1'b0;
    end
    for (int k = 0; k <= rdy_dly; k++) begin
      redirect_ready_i = (k == rdy_dly);
      @(negedge clk);
      chk1("redirect_valid", redirect_valid_o, 1'b1);
      chk("redirect_pc", redirect_pc_o, v.target);
      chk1("trap_ret", trap_ret_o, (v.kind == K_MRET) && (k == 0));
      chk1("csr_we_redirect", csr_we_o, 1'b0);
      chk1("busy_redirect", busy_o, 1'b1);
      chk1("flush_redirect", flush_o, 1'b1);
      @(posedge clk); #1;
    end
    redirect_ready_i = 1'b0;
    @(negedge clk);
    chk1("busy_after", busy_o, 1'b0);
    chk1("redirect_valid_after", redirect_valid_o, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    vec_t v;

    rst_i = 1'b0;
    mie_i = '0; mtvec_i = '0; pc_i = '0; instruction_i = '0; mem_addr_i = '0; mepc_i = '0;
    mstatus_mie_i = 1'b1;
    idle_inputs();
    wb_valid_i = 1'b1; exc_i = 6'b000010;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_kill_wb", kill_wb_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_flush", flush_o, 1'b0);
    chk1("rst_csr_we", csr_we_o, 1'b0);
    chk1("rst_redirect_valid", redirect_valid_o, 1'b0);
    chk("rst_mcause", mcause_o, 32'h0);
    chk("rst_redirect_pc", redirect_pc_o, 32'h0);
    @(posedge clk); #1;
    idle_inputs();
    rst_i = 1'b1;

    //             wb exc        mret ei ti si plat     g  mie           mtvec          pc            instr         addr          mepc          kind    cause         mtval         target
    tbl.push_back(mk(1, 6'b000010, 0, 0, 0, 0, 4'b0000, 0, 32'h0,        32'h0,         32'h100,      32'hFFFF_FFFF, 32'h0,       32'h0,        K_TRAP, 32'h2,        32'hFFFF_FFFF, 32'h0));
    tbl.push_back(mk(1, 6'b010000, 0, 0, 0, 0, 4'b0000, 0, 32'h0,        32'h8000_0000, 32'h300,      32'h0,        32'h2003,     32'h0,        K_TRAP, 32'h4,        32'h2003,     32'h8000_0000));
    tbl.push_back(mk(1, 6'b000000, 0, 0, 1, 0, 4'b0000, 1, 32'h80,       32'h401,       32'h500,      32'h0,        32'h0,        32'h0,        K_TRAP, 32'h8000_0007, 32'h0,       32'h41C));
    tbl.push_back(mk(1, 6'b000010, 0, 0, 1, 0, 4'b0000, 1, 32'h80,       32'h401,       32'h504,      32'h1234,     32'h0,        32'h0,        K_TRAP, 32'h8000_0007, 32'h0,       32'h41C));
    tbl.push_back(mk(1, 6'b000010, 0, 0, 1, 0, 4'b0000, 1, 32'h0,        32'h401,       32'h508,      32'h1234,     32'h0,        32'h0,        K_TRAP, 32'h2,        32'h1234,     32'h400));
    tbl.push_back(mk(1, 6'b001100, 0, 0, 0, 0, 4'b0000, 0, 32'h0,        32'h1001,      32'h60C,      32'h0,        32'h0,        32'h0,        K_TRAP, 32'h3,        32'h60C,      32'h1000));
    tbl.push_back(mk(1, 6'b100000, 0, 0, 0, 0, 4'b0000, 0, 32'h0,        32'h2000,      32'h700,      32'h0,        32'hABCD,     32'h0,        K_TRAP, 32'h6,        32'hABCD,     32'h2000));
    tbl.push_back(mk(1, 6'b100001, 0, 0, 0, 0, 4'b0000, 0, 32'h0,        32'h2000,      32'h102,      32'h0,        32'hABCD,     32'h0,        K_TRAP, 32'h0,        32'h102,      32'h2000));
    tbl.push_back(mk(1, 6'b001000, 0, 0, 0, 0, 4'b0000, 0, 32'h0,        32'h2000,      32'h800,      32'h0,        32'h0,        32'h0,        K_TRAP, 32'hB,        32'h0,        32'h2000));
    tbl.push_back(mk(1, 6'b000000, 0, 1, 1, 1, 4'b0000, 1, 32'h888,      32'h401,       32'h900,      32'h0,        32'h0,        32'h0,        K_TRAP, 32'h8000_000B, 32'h0,       32'h42C));
    tbl.push_back(mk(1, 6'b000000, 0, 0, 1, 1, 4'b0000, 1, 32'h88,       32'h401,       32'h904,      32'h0,        32'h0,        32'h0,        K_TRAP, 32'h8000_0003, 32'h0,       32'h40C));
    tbl.push_back(mk(1, 6'b000000, 1, 0, 1, 0, 4'b0000, 0, 32'h80,       32'h401,       32'hA00,      32'h0,        32'h0,        32'h200,      K_MRET, 32'h0,        32'h0,        32'h200));
    tbl.push_back(mk(1, 6'b000000, 0, 0, 0, 0, 4'b0100, 1, 32'h4_0000,   32'hFFFF_FFF1, 32'hB00,      32'h0,        32'h0,        32'h0,        K_TRAP, 32'h8000_0012, 32'h0,       32'h38));
    tbl.push_back(mk(1, 6'b000000, 0, 0, 0, 0, 4'b1010, 1, 32'hA_0000,   32'h1,         32'hB04,      32'h0,        32'h0,        32'h0,        K_TRAP, 32'h8000_0011, 32'h0,       32'h44));
    tbl.push_back(mk(1, 6'b000000, 0, 0, 1, 0, 4'b0000, 1, 32'h0,        32'h0,         32'hC00,      32'h0,        32'h0,        32'h0,        K_NONE, 32'h0,        32'h0,        32'h0));
    tbl.push_back(mk(0, 6'b000010, 1, 0, 0, 0, 4'b0000, 0, 32'h0,        32'h0,         32'hC04,      32'h0,        32'h0,        32'h0,        K_NONE, 32'h0,        32'h0,        32'h0));

    for (int i = 0; i < tbl.size(); i++) do_event(tbl[i], 0, 1'b0);

    do_event(tbl[11], 3, 1'b0);

    do_event(tbl[0], 0, 1'b1);
    v = mk(1, 6'b0, 0, 0, 0, 0, 4'b0000, 1, 32'h1_0000, 32'h3000, 32'hD00, 32'h0, 32'h0, 32'h0,
           K_TRAP, 32'h8000_0010, 32'h0, 32'h3000);
    do_event(v, 1, 1'b0);
    v.kind = K_NONE;
    do_event(v, 0, 1'b0);

    drive(tbl[0]);
    @(posedge clk); #1;
    idle_inputs();
    rst_i = 1'b0;
    @(negedge clk);
    chk1("rst_in_commit_csr_we", csr_we_o, 1'b0);
    chk1("rst_in_commit_trap_enter", trap_enter_o, 1'b0);
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(negedge clk);
    chk1("post_rst_busy", busy_o, 1'b0);
    chk1("post_rst_csr_we", csr_we_o, 1'b0);
    chk("post_rst_mcause", mcause_o, 32'h0);
    @(posedge clk); #1;
    m_edge = 1'b0;

    for (int n = 0; n < 60; n++) begin
      bit pulse;
      int dly;
      v.wb    = ($urandom_range(0, 7) != 0);
      v.exc   = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      v.mret  = ($urandom_range(0, 3) == 0);
      v.meip  = ($urandom_range(0, 4) == 0);
      v.mtip  = ($urandom_range(0, 4) == 0);
      v.msip  = ($urandom_range(0, 4) == 0);
      v.plat  = 4'($urandom) & 4'b1110;
      v.mie_g = 1'($urandom);
      v.mie   = $urandom;
      v.mtvec = $urandom;
      if ($urandom_range(0, 1) == 1) v.mtvec[1:0] = 2'b01;
      v.pc    = $urandom;
      v.instr = $urandom;
      v.addr  = $urandom;
      v.mepc  = $urandom;
      v       = model(v, m_edge);
      pulse   = (v.kind == K_TRAP) && ($urandom_range(0, 3) == 0);
      dly     = $urandom_range(0, 2);
      do_event(v, dly, pulse);
      if (v.kind == K_TRAP && v.cause == 32'h8000_0010) m_edge = 1'b0;
      if (pulse) m_edge = 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
